// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs RV32I I/S/SB fields into words and streams them into imem
// Range/alignment failures latch a sticky error instead of writing.
module instr_encoder_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {S_READY, S_WRITE, S_FULL, S_ERROR} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;

  logic [6:0]          opcode;
  logic [31:0]         enc_word;
  logic                chk_fail;
  logic [1:0]          chk_code;
  logic [CW-1:0]       count_inc;
  logic [ADDR_W-1:0]   addr_next;

  assign count_inc = count_q + CW'(1);
  assign addr_next = ADDR_W'({count_q, 2'b00});

  always_comb begin
    opcode   = 7'h03;
    enc_word = '0;
    chk_fail = 1'b0;
    chk_code = 2'b00;
    case (fmt)
      2'b00:   opcode = 7'h03;
      2'b01:   opcode = 7'h13;
      2'b10:   opcode = 7'h23;
      default: opcode = 7'h63;
    endcase
    case (fmt)
      2'b00, 2'b01: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      2'b10:        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      default:      enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
    endcase
    // Range is judged first so an out-of-range odd branch reports 01, not 10.
    if (fmt == 2'b11) begin
      if (!((&imm[31:12]) || !(|imm[31:12]))) begin
        chk_fail = 1'b1;
        chk_code = 2'b01;
      end else if (imm[0]) begin
        chk_fail = 1'b1;
        chk_code = 2'b10;
      end
    end else if (!((&imm[31:11]) || !(|imm[31:11]))) begin
      chk_fail = 1'b1;
      chk_code = 2'b01;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_READY;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    code_d  = code_q;
    if (clear) begin
      state_d = S_READY;
      count_d = '0;
      err_d   = 1'b0;
      code_d  = 2'b00;
    end else begin
      case (state_q)
        S_READY: begin
          if (in_valid) begin
            if (chk_fail) begin
              state_d = S_ERROR;
              err_d   = 1'b1;
              code_d  = chk_code;
            end else begin
              state_d = S_WRITE;
              addr_d  = addr_next;
              wdata_d = enc_word;
            end
          end
        end
        S_WRITE: begin
          count_d = count_inc;
          state_d = (count_inc == CW'(DEPTH)) ? S_FULL : S_READY;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == S_READY) && !clear;
    mem_we    = (state_q == S_WRITE);
    full      = (count_q == CW'(DEPTH));
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    count     = count_q;
    err       = err_q;
    err_code  = code_q;
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - scoreboard bench for instr_encoder_loader
module tb_instr_encoder_loader;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              sysclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic [1:0]        fmt = '0;
  logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]        funct3 = '0;
  logic [31:0]       imm = '0;
  logic              in_ready, mem_we, full, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [CW-1:0]     count;
  logic [1:0]        err_code;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
    .full(full), .err(err), .err_code(err_code)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] word;
    logic [31:0] imm;
    logic [1:0]  fmt;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         tests = 0;
  int         fails = 0;
  int         m_count = 0;
  bit         m_err = 0;
  logic [1:0] m_code = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_encode(input logic [1:0] f, input logic [4:0] d, s1, s2,
                                               input logic [2:0] f3, input logic [31:0] u);
    logic [31:0] op;
    logic [31:0] w;
    op = (f == 0) ? 32'h03 : (f == 1) ? 32'h13 : (f == 2) ? 32'h23 : 32'h63;
    w = op | (32'(f3) << 12) | (32'(s1) << 15);
    if (f < 2)
      w = w | ((u & 32'hFFF) << 20) | (32'(d) << 7);
    else if (f == 2)
      w = w | (((u >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | ((u & 32'h1F) << 7);
    else
      w = w | (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
            | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
    return w;
  endfunction

  function automatic logic [31:0] decode_imm(input logic [1:0] f, input logic [31:0] w);
    if (f < 2)       return {{20{w[31]}}, w[31:20]};
    else if (f == 2) return {{20{w[31]}}, w[31:25], w[11:7]};
    else             return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  task automatic model_accept(input logic [1:0] f, input logic [4:0] d, s1, s2,
                              input logic [2:0] f3, input logic [31:0] im, input logic [32:0] golden);
    int si;
    bit bad;
    logic [1:0] code;
    wr_t e;
    si = $signed(im);
    code = 2'b01;
    if (f == 3) begin
      bad = (si < -4096) || (si > 4095);
      if (!bad && im[0]) begin bad = 1; code = 2'b10; end
    end else begin
      bad = (si < -2048) || (si > 2047);
    end
    if (bad) begin
      m_err = 1;
      m_code = code;
    end else begin
      e.addr = 8'(m_count * 4);
      e.word = golden[32] ? golden[31:0] : model_encode(f, d, s1, s2, f3, im);
      e.imm  = im;
      e.fmt  = f;
      exp_q.push_back(e);
      m_count++;
    end
  endtask

  always @(negedge sysclk) begin
    if (rst_n && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("wr_data", mem_wdata, mon_e.word);
        check("roundtrip_imm", decode_imm(mon_e.fmt, mem_wdata), mon_e.imm);
      end
    end
  end

  task automatic send(input logic [1:0] f, input logic [4:0] d, s1, s2,
                      input logic [2:0] f3, input logic [31:0] im, input logic [32:0] golden);
    int n;
    @(negedge sysclk);
    fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge sysclk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge sysclk);
      #1;
      in_valid = 1'b0;
      model_accept(f, d, s1, s2, f3, im, golden);
    end
  endtask

  task automatic send_rand(input logic [31:0] im);
    send(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), im, 33'h0);
  endtask

  task automatic check_status();
    @(posedge sysclk);
    @(negedge sysclk);
    check("count", 32'(count), 32'(m_count));
    check("full", 32'(full), 32'(m_count == DEPTH));
    check("err", 32'(err), 32'(m_err));
    check("err_code", 32'(err_code), 32'(m_code));
    check("in_ready", 32'(in_ready), 32'(!m_err && m_count != DEPTH));
  endtask

  task automatic do_clear();
    @(negedge sysclk);
    clear = 1'b1;
    @(negedge sysclk);
    clear = 1'b0;
    m_count = 0; m_err = 0; m_code = 2'b00;
  endtask

  function automatic logic [31:0] rand_imm();
    int pick;
    int corners[9] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, 4095, -4097};
    pick = int'($urandom_range(0, 3));
    case (pick)
      0:       return 32'(int'($urandom_range(0, 4095)) - 2048);
      1:       return 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
      2:       return $urandom;
      default: return 32'(corners[$urandom_range(0, 8)]);
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge sysclk);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_count", 32'(count), 0);
    check("rst_full", 32'(full), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_code", 32'(err_code), 0);
    rst_n = 1'b1;

    send(2'b01, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, {1'b1, 32'h00500093});
    check_status();
    do_clear();
    send(2'b00, 5'd2, 5'd1, 5'd0, 3'd2, -32'sd4, {1'b1, 32'hFFC0A103});
    check_status();
    send(2'b10, 5'd0, 5'd2, 5'd5, 3'd2, 32'd8, {1'b1, 32'h00512423});
    check_status();
    do_clear();
    send(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8, {1'b1, 32'hFE208CE3});
    check_status();

    do_clear();
    send(2'b01, 5'd3, 5'd1, 5'd0, 3'd0, 32'd2048, 33'h0);
    check_status();
    repeat (3) @(negedge sysclk);
    check("err_hold_in_ready", 32'(in_ready), 0);
    do_clear();
    check_status();
    send(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 33'h0);
    check_status();
    do_clear();
    send(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4096, 33'h0);
    check_status();

    do_clear();
    for (int i = 0; i < DEPTH; i++) send(2'b01, 5'(i), 5'd0, 5'd0, 3'd0, 32'(i * 3), 33'h0);
    check_status();
    @(negedge sysclk);
    in_valid = 1'b1;
    repeat (5) @(negedge sysclk);
    check("full_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    check_status();
    do_clear();
    send(2'b10, 5'd0, 5'd4, 5'd6, 3'd2, 32'd12, 33'h0);
    check_status();

    do_clear();
    send(2'b01, 5'd7, 5'd1, 5'd0, 3'd0, 32'd9, 33'h0);
    clear = 1'b1;
    @(posedge sysclk);
    #1;
    clear = 1'b0;
    m_count = 0;
    @(negedge sysclk);
    check("clear_in_write_count", 32'(count), 0);
    check("clear_in_write_ready", 32'(in_ready), 1);

    send(2'b01, 5'd7, 5'd1, 5'd0, 3'd0, 32'd9, 33'h0);
    #2;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    m_count = 0; m_err = 0; m_code = 2'b00;
    #1;
    check("rst_mid_mem_we", 32'(mem_we), 0);
    check("rst_mid_addr", 32'(mem_addr), 0);
    check("rst_mid_wdata", mem_wdata, 0);
    check("rst_mid_count", 32'(count), 0);
    @(negedge sysclk);
    rst_n = 1'b1;

    @(negedge sysclk);
    fmt = 2'b01; rd = 5'd1; rs1 = 5'd0; funct3 = 3'd0; imm = 32'd1;
    in_valid = 1'b1; clear = 1'b1;
    #1;
    check("clear_valid_in_ready", 32'(in_ready), 0);
    @(negedge sysclk);
    in_valid = 1'b0; clear = 1'b0;
    @(negedge sysclk);
    check("clear_valid_count", 32'(count), 0);

    for (int i = 0; i < 150; i++) begin
      if (m_err || m_count == DEPTH) do_clear();
      send_rand(rand_imm());
      check_status();
    end

    repeat (3) @(negedge sysclk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the datapath immediate decoder: accepts instruction fields plus a signed 32-bit immediate and packs them into a 32-bit RV32I word (I-load, I-ALU, S, SB formats).
- Range-checks the immediate, then writes the word into instruction memory at an auto-incrementing byte address.
- Used as the program loader and testbench stimulus source that feeds imem before the core runs.
- Every encoding round-trips through the decoder's immediate extraction.

Parameters:
- DEPTH, 64, number of 32-bit words in target imem; must be ≥2 and ≤ 2^(ADDR_W-2).
- ADDR_W, 8, byte-address width of mem_addr.

Ports:
- sysclk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear: pointer, count, error, state
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept a bundle
- fmt  in  2  00 I-load (op 0x03), 01 I-ALU (0x13), 10 S (0x23), 11 SB (0x63)
- rd  in  5  destination register (I only; ignored for S/SB)
- rs1  in  5  source register 1
- rs2  in  5  source register 2 (S/SB only)
- funct3  in  3  funct3 field
- imm  in  32  signed immediate, two's complement
- mem_we  out  1  imem write strobe, one cycle per word
- mem_addr  out  ADDR_W  imem byte address
- mem_wdata  out  32  encoded instruction
- count  out  $clog2(DEPTH+1)  words written since reset/clear
- full  out  1  count == DEPTH
- err  out  1  sticky error flag
- err_code  out  2  01 range, 10 misaligned branch; 00 when err=0

Behaviour:
- Reset (rst_n low, async): state READY; mem_we=0; mem_addr=0; mem_wdata=0; count=0; full=0; err=0; err_code=00.
- FSM states READY, WRITE, FULL, ERROR; in_ready = (state==READY) && !clear.
- Accept = in_valid && in_ready, sampled on a sysclk edge.
- On accept, encode and check combinationally from the inputs; register mem_wdata and mem_addr = count*4.
- Accept with check passing: next state WRITE.
- Accept with check failing: next state ERROR; err=1; err_code set; no write; pointer unchanged.
- WRITE: mem_we=1 for exactly this cycle (registered, no combinational path from inputs). count increments at the end of the cycle. Next state is FULL if the new count == DEPTH, else READY.
- Throughput: one word per 2 cycles. Latency: accept edge -> mem_we high the following cycle.
- FULL: full=1, in_ready=0; in_valid ignored until clear.
- ERROR: in_ready=0; err and err_code hold until clear or reset.
- Encodings (opcode from fmt):
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- Checks:
  - I/S: imm[31:11] all equal (range −2048..2047), else err_code 01.
  - SB: imm[31:12] all equal (range −4096..4094), else 01; otherwise imm[0]==1 gives 10. Range takes precedence over misalignment.
- clear has priority over accept. clear during WRITE: mem_we still asserted that cycle (word lands), then count=0, state READY, err=0, full=0. Any state + clear -> READY.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Reset mid-WRITE: mem_we drops immediately (async), all state per reset values.

Test Plan:
- addi x1,x0,5 (fmt=01, rd=1, rs1=0, funct3=0, imm=5) -> one-cycle mem_we, mem_addr=0x00, mem_wdata=0x00500093; count=1; in_ready back high the next cycle.
- lw x2,-4(x1) (fmt=00, rd=2, rs1=1, funct3=2, imm=−4), then sw x5,8(x2) (fmt=10, rs1=2, rs2=5, funct3=2, imm=8) -> 0xFFC0A103 @0x00, 0x00512423 @0x04.
- beq x1,x2,-8 (fmt=11, rs1=1, rs2=2, funct3=0, imm=−8) -> 0xFE208CE3; decoding that word yields imm=0xFFFFFFF8.
- Errors:
  - fmt=01 imm=2048 -> err=1, err_code=01, no mem_we, in_ready=0 until clear.
  - After clear, fmt=11 imm=3 -> err_code=10.
  - fmt=11 imm=4096 -> err_code=01.
- DEPTH=4: four valid bundles back-to-back -> addresses 0,4,8,12; full=1, count=4; fifth bundle never accepted, no mem_we; clear -> count=0, next word @0x00.
- Timing corner cases:
  - clear asserted on the WRITE cycle -> write completes, count=0.
  - rst_n pulsed low mid-WRITE -> mem_we=0 within the same cycle, all outputs at reset values.
  - clear and in_valid together in READY -> no accept.
